// File: rtl/register_cmd_pkg.sv
// -----------------------------------------------------------------------------
// register_cmd_pkg
// Shared definitions for the 4-bit shift register block and its sequencer:
//   - cmd_e   : 3-bit register command codes driven on the register's command
//               input (also decoded by the register block itself)
//   - op_e    : 2-bit request operation codes presented by the clients
//   - state_e : sequencer FSM states
// Helper functions translate a client operation into the register command.
// -----------------------------------------------------------------------------
package register_cmd_pkg;

    localparam int unsigned SEQ_DATA_WIDTH = 4;
    localparam int unsigned SEQ_CNT_WIDTH  = 3;

    typedef enum logic [2:0] {
        CMD_HOLD  = 3'b000,
        CMD_RESET = 3'b001,
        CMD_LOAD  = 3'b010,
        CMD_SHL   = 3'b011,
        CMD_SHR   = 3'b100
    } cmd_e;

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_LOAD  = 2'b01,
        OP_SHL   = 2'b10,
        OP_SHR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Register command issued for each cycle of a client operation.
    function automatic cmd_e op_to_cmd(input op_e op);
        cmd_e cmd;
        case (op)
            OP_RESET: cmd = CMD_RESET;
            OP_LOAD:  cmd = CMD_LOAD;
            OP_SHL:   cmd = CMD_SHL;
            OP_SHR:   cmd = CMD_SHR;
            default:  cmd = CMD_HOLD;
        endcase
        return cmd;
    endfunction

    // Shift operations are the only multi-cycle (count-driven) ones.
    function automatic logic op_is_shift(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/sequencer_arbiter.sv
// -----------------------------------------------------------------------------
// sequencer_arbiter
// Picks which of the two clients is served when the sequencer arbitrates.
// Build option SEQ_ROUND_ROBIN_EN:
//   defined   - ties go to the client not served last; the last-served flag
//               updates on every accepted grant and resets to B, so A wins the
//               first tie after reset.
//   undefined - fixed priority, A always wins ties; no state is kept.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   reqA      client A request level
//   reqB      client B request level
//   accept_i  strobe: the sequencer is taking the current winner this cycle
//   sel_b_o   winner select (0 = A, 1 = B); only meaningful when a request is up
// -----------------------------------------------------------------------------
module sequencer_arbiter (
    input  logic clk_i,
    input  logic rst_i,
    input  logic reqA,
    input  logic reqB,
    input  logic accept_i,
    output logic sel_b_o
);

`ifdef SEQ_ROUND_ROBIN_EN
    logic last_b_q;
    logic last_b_d;

    // Winner select: a tie goes to whoever was not served last.
    always_comb begin
        sel_b_o = 1'b0;
        if (reqA && reqB) begin
            sel_b_o = ~last_b_q;
        end else if (reqB) begin
            sel_b_o = 1'b1;
        end else begin
            sel_b_o = 1'b0;
        end
    end

    // Last-served next state: follows the winner on every accepted grant.
    always_comb begin
        last_b_d = last_b_q;
        if (accept_i) begin
            last_b_d = sel_b_o;
        end else begin
            last_b_d = last_b_q;
        end
    end

    // Last-served register; resets to B so that A takes the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`else
    // Fixed priority needs neither the clock nor the accept strobe.
    logic unused_s;
    assign unused_s = clk_i ^ rst_i ^ accept_i;

    // Winner select: A wins whenever it is requesting.
    always_comb begin
        sel_b_o = 1'b0;
        if (reqA) begin
            sel_b_o = 1'b0;
        end else begin
            sel_b_o = reqB;
        end
    end
`endif

endmodule

// File: rtl/register_sequencer.sv
// -----------------------------------------------------------------------------
// register_sequencer
// Command sequencer and two-requester arbiter sitting in front of a single
// 4-bit shift register. A granted client's operation (RESET, LOAD, shift
// left/right by N) is expanded into register commands, one per cycle, and a
// done pulse is returned to that client once the register holds the result.
// Optional build macro: SEQ_ROUND_ROBIN_EN (round-robin tie-breaking inside
// sequencer_arbiter; fixed A-priority when undefined).
// Ports:
//   clockSequencer        clock, rising edge
//   resetSequencer        synchronous active-high reset
//   reqA/reqB             request levels, held until the client's grant pulse
//   opA/opB               operation code (op_e)
//   dataA/dataB           load value (LOAD only)
//   countA/countB         shift count (shifts only)
//   grantA/grantB         one-cycle pulse: request accepted, operands latched
//   doneA/doneB           one-cycle pulse: operation complete
//   busy                  high whenever the FSM is not IDLE
//   commandOut            register command (cmd_e)
//   dataOut               register data; the load value during LOAD, else 0
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module register_sequencer
    import register_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SEQ_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = SEQ_CNT_WIDTH
) (
    input  logic                  clockSequencer,
    input  logic                  resetSequencer,
    input  logic                  reqA,
    input  logic                  reqB,
    input  logic [1:0]            opA,
    input  logic [1:0]            opB,
    input  logic [DATA_WIDTH-1:0] dataA,
    input  logic [DATA_WIDTH-1:0] dataB,
    input  logic [CNT_WIDTH-1:0]  countA,
    input  logic [CNT_WIDTH-1:0]  countB,
    output logic                  grantA,
    output logic                  grantB,
    output logic                  doneA,
    output logic                  doneB,
    output logic                  busy,
    output logic [2:0]            commandOut,
    output logic [DATA_WIDTH-1:0] dataOut
);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  owner_b_q, owner_b_d;
    cmd_e                  cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  grant_a_q, grant_a_d;
    logic                  grant_b_q, grant_b_d;
    logic                  done_a_q, done_a_d;
    logic                  done_b_q, done_b_d;
    logic                  busy_q, busy_d;

    logic                  accept_s;
    logic                  sel_b_s;
    op_e                   win_op_s;
    logic [DATA_WIDTH-1:0] win_data_s;
    logic [CNT_WIDTH-1:0]  win_cnt_s;

    assign accept_s = (state_q == ST_IDLE) && (reqA || reqB);

    sequencer_arbiter u_arbiter (
        .clk_i    (clockSequencer),
        .rst_i    (resetSequencer),
        .reqA     (reqA),
        .reqB     (reqB),
        .accept_i (accept_s),
        .sel_b_o  (sel_b_s)
    );

    // Operand mux: the winning client's op, data and count.
    always_comb begin
        win_op_s   = op_e'(opA);
        win_data_s = dataA;
        win_cnt_s  = countA;
        if (sel_b_s) begin
            win_op_s   = op_e'(opB);
            win_data_s = dataB;
            win_cnt_s  = countB;
        end else begin
            win_op_s   = op_e'(opA);
            win_data_s = dataA;
            win_cnt_s  = countA;
        end
    end

    // FSM next state and next registered outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        owner_b_d = owner_b_q;
        cmd_d     = CMD_HOLD;
        data_d    = {DATA_WIDTH{1'b0}};
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        done_a_d  = 1'b0;
        done_b_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    owner_b_d = sel_b_s;
                    op_d      = win_op_s;
                    grant_a_d = ~sel_b_s;
                    grant_b_d = sel_b_s;
                    if (op_is_shift(win_op_s)) begin
                        if (win_cnt_s == {CNT_WIDTH{1'b0}}) begin
                            // Nothing to shift: complete in the grant cycle.
                            cnt_d    = {CNT_WIDTH{1'b0}};
                            done_a_d = ~sel_b_s;
                            done_b_d = sel_b_s;
                            state_d  = ST_DONE;
                        end else begin
                            // First shift goes out now; N-1 remain.
                            cnt_d   = win_cnt_s - CNT_WIDTH'(1'b1);
                            cmd_d   = op_to_cmd(win_op_s);
                            state_d = ST_EXEC;
                        end
                    end else begin
                        cnt_d   = {CNT_WIDTH{1'b0}};
                        cmd_d   = op_to_cmd(win_op_s);
                        state_d = ST_EXEC;
                        if (win_op_s == OP_LOAD) begin
                            data_d = win_data_s;
                        end else begin
                            data_d = {DATA_WIDTH{1'b0}};
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_q == {CNT_WIDTH{1'b0}}) begin
                    // Last command was sampled at this edge: report done.
                    done_a_d = ~owner_b_q;
                    done_b_d = owner_b_q;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_WIDTH'(1'b1);
                    cmd_d   = op_to_cmd(op_q);
                    state_d = ST_EXEC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset wins over any arbitration.
    always_ff @(posedge clockSequencer) begin
        if (resetSequencer) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_RESET;
            cnt_q     <= {CNT_WIDTH{1'b0}};
            owner_b_q <= 1'b0;
            cmd_q     <= CMD_HOLD;
            data_q    <= {DATA_WIDTH{1'b0}};
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            owner_b_q <= owner_b_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            busy_q    <= busy_d;
        end
    end

    assign grantA     = grant_a_q;
    assign grantB     = grant_b_q;
    assign doneA      = done_a_q;
    assign doneB      = done_b_q;
    assign busy       = busy_q;
    assign commandOut = cmd_q;
    assign dataOut    = data_q;

endmodule
